// File: rtl/alu_writeback.sv
// Writeback stage: EX/WB register, 16-entry register file, flag/overflow/retire state.
// Optional define WB_BYPASS_EN forwards the pending commit to the read ports.
module alu_writeback #(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_valid,
  input  logic          ex_we,
  input  logic [AW-1:0] ex_rd,
  input  logic [3:0]    ex_func,
  input  logic [DW-1:0] ex_op,
  input  logic [DW-1:0] ex_r0,
  input  logic          ex_flag,
  input  logic          ex_oflw,
  input  logic          ovf_clr,
  input  logic [AW-1:0] rs1_addr,
  input  logic [AW-1:0] rs2_addr,
  output logic [DW-1:0] rs1_data,
  output logic [DW-1:0] rs2_data,
  output logic          wb_valid,
  output logic          flag_q,
  output logic          ovf_sticky,
  output logic [15:0]   retired
);

  localparam int NR = 1 << AW;
  localparam logic [3:0] FN_MUL = 4'b0100;
  localparam logic [3:0] FN_DIV = 4'b0101;

  logic          valid_q;
  logic          we_q;
  logic [AW-1:0] rd_q;
  logic [3:0]    func_q;
  logic [DW-1:0] op_q;
  logic [DW-1:0] r0_q;
  logic          wflag_q;
  logic          oflw_q;

  logic [DW-1:0] rf_q [NR];
  logic          aflag_q;
  logic          ovf_q;
  logic          ovf_d;
  logic [15:0]   ret_q;
  logic [15:0]   ret_d;

  logic prim_we;
  logic aux_fn;
  logic aux_we;

  assign prim_we = valid_q & we_q;
  assign aux_fn  = (func_q == FN_MUL) || (func_q == FN_DIV);
  // A primary write to R0 wins over the auxiliary result.
  assign aux_we  = valid_q & aux_fn & ~(prim_we & (rd_q == '0));

  assign ovf_d = (valid_q & oflw_q) | (ovf_q & ~ovf_clr);
  assign ret_d = valid_q ? ret_q + 16'd1 : ret_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      rd_q    <= '0;
      func_q  <= '0;
      op_q    <= '0;
      r0_q    <= '0;
      wflag_q <= 1'b0;
      oflw_q  <= 1'b0;
      aflag_q <= 1'b0;
      ovf_q   <= 1'b0;
      ret_q   <= '0;
      for (int i = 0; i < NR; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      valid_q <= ex_valid;
      if (ex_valid) begin
        we_q    <= ex_we;
        rd_q    <= ex_rd;
        func_q  <= ex_func;
        op_q    <= ex_op;
        r0_q    <= ex_r0;
        wflag_q <= ex_flag;
        oflw_q  <= ex_oflw;
      end
      if (aux_we) begin
        rf_q[0] <= r0_q;
      end
      if (prim_we) begin
        rf_q[rd_q] <= op_q;
      end
      if (valid_q) begin
        aflag_q <= wflag_q;
      end
      ovf_q <= ovf_d;
      ret_q <= ret_d;
    end
  end

  logic [AW-1:0] ra   [2];
  logic [DW-1:0] rdat [2];

  assign ra[0] = rs1_addr;
  assign ra[1] = rs2_addr;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdat[p] = rf_q[ra[p]];
`ifdef WB_BYPASS_EN
      if (prim_we && (rd_q == ra[p])) begin
        rdat[p] = op_q;
      end else if (aux_we && (ra[p] == '0)) begin
        rdat[p] = r0_q;
      end
`endif
    end
  end

  assign rs1_data   = rdat[0];
  assign rs2_data   = rdat[1];
  assign wb_valid   = valid_q;
  assign flag_q     = aflag_q;
  assign ovf_sticky = ovf_q;
  assign retired    = ret_q;

endmodule
